// File: rtl/ahb_sram_bridge.sv
// ahb_sram_bridge: zero-wait AHB-Lite to single-port SRAM bridge (ahb: hsel/haddr/htrans/hwrite/hsize/hwdata/hready -> hreadyout/hresp/hrdata; sram: cen/wen/addr/din <- dout) with a one-entry posted write buffer
module ahb_sram_bridge (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata,
  output logic        sram_cen,
  output logic [3:0]  sram_wen,
  output logic [9:0]  sram_addr,
  output logic [31:0] sram_din,
  input  logic [31:0] sram_dout
);
  typedef enum logic [1:0] {OKAY, ERR1, ERR2} state_t;
  state_t state, state_nxt;
  logic acc, legal, rd_acc, wr_acc, err_acc, drain, hit;
  logic [3:0] lanes;
  logic rd_dp, wr_dp;
  logic [9:0] dp_addr;
  logic [3:0] dp_lanes;
  logic buf_v;
  logic [9:0] buf_addr;
  logic [3:0] buf_lanes;
  logic [31:0] buf_data, merged;
  logic unused;
  assign unused = ^{haddr[31:12], htrans[0]};
  assign acc = rst_n & hsel & htrans[1] & hready & (state != ERR1);
  assign legal = (hsize == 3'd0) | ((hsize == 3'd1) & ~haddr[0]) | ((hsize == 3'd2) & (haddr[1:0] == 2'd0));
  assign lanes = hsize == 3'd0 ? 4'b0001 << haddr[1:0] : hsize == 3'd1 ? (haddr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign rd_acc = acc & legal & ~hwrite;
  assign wr_acc = acc & legal & hwrite;
  assign err_acc = acc & ~legal;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= OKAY;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state == ERR1 ? ERR2 : err_acc ? ERR1 : OKAY;
    hreadyout = state != ERR1;
    hresp = state != OKAY;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_dp <= 1'b0;
      wr_dp <= 1'b0;
      dp_addr <= '0;
      dp_lanes <= '0;
      buf_v <= 1'b0;
      buf_addr <= '0;
      buf_lanes <= '0;
      buf_data <= '0;
    end else begin
      if (hready) begin
        rd_dp <= rd_acc;
        wr_dp <= wr_acc;
        dp_addr <= haddr[11:2];
        dp_lanes <= lanes;
      end
      if (wr_dp & hready) begin
        buf_v <= 1'b1;
        buf_addr <= dp_addr;
        buf_lanes <= dp_lanes;
        buf_data <= hwdata;
      end else if (drain) buf_v <= 1'b0;
    end
  assign drain = buf_v & ~rd_acc;
  assign sram_cen = ~(rd_acc | buf_v);
  assign sram_wen = drain ? ~buf_lanes : 4'hF;
  assign sram_addr = rd_acc ? haddr[11:2] : drain ? buf_addr : 10'd0;
  assign sram_din = drain ? buf_data : 32'd0;
  assign hit = buf_v & (buf_addr == dp_addr);
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign merged[8*i +: 8] = hit & buf_lanes[i] ? buf_data[8*i +: 8] : sram_dout[8*i +: 8];
  end
  assign hrdata = rd_dp ? merged : 32'd0;
endmodule

// File: tb/tb_ahb_sram_bridge.sv
// tb_ahb_sram_bridge: directed bench with a bus-level memory model, per-cycle response compare and literal pins
module tb_ahb_sram_bridge;
  logic clk = 1'b0, rst_n = 1'b0, hsel = 1'b0, hwrite = 1'b0, hready = 1'b1;
  logic [31:0] haddr = '0, hwdata = '0;
  logic [1:0] htrans = '0;
  logic [2:0] hsize = '0;
  logic hreadyout, hresp, sram_cen;
  logic [31:0] hrdata, sram_din;
  logic [31:0] sram_dout = '0;
  logic [3:0] sram_wen;
  logic [9:0] sram_addr;
  ahb_sram_bridge dut (
    .clk(clk), .rst_n(rst_n), .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hwdata(hwdata), .hready(hready), .hreadyout(hreadyout), .hresp(hresp),
    .hrdata(hrdata), .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout)
  );
  always #5 clk = ~clk;
  logic [31:0] mem [1024];
  always @(posedge clk)
    if (!sram_cen) begin
      if (&sram_wen) sram_dout <= mem[sram_addr];
      else for (int i = 0; i < 4; i++) if (!sram_wen[i]) mem[sram_addr][8*i +: 8] <= sram_din[8*i +: 8];
    end
  logic [7:0] ref_mem [4096];
  bit prd_v, n_prd_v, pw_v, n_pw_v, last_rdy = 1'b1, chk_en;
  logic [31:0] prd_data, n_prd_data;
  logic [11:0] pw_base, n_pw_base;
  logic [3:0] pw_en, n_pw_en;
  int err_left, n_err;
  logic exp_ready, exp_resp;
  logic [31:0] exp_rdata;
  int n_chk, n_fail;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (chk_en) begin
      chk("hreadyout", {31'd0, hreadyout}, {31'd0, exp_ready});
      chk("hresp", {31'd0, hresp}, {31'd0, exp_resp});
      chk("hrdata", hrdata, exp_rdata);
    end
  task automatic cyc(input logic sel, input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                     input logic [11:0] a, input logic [31:0] wd, input logic rdy);
    bit acc, legal;
    logic [11:0] base;
    @(posedge clk);
    #1;
    if (last_rdy) begin
      prd_v = n_prd_v; prd_data = n_prd_data;
      pw_v = n_pw_v; pw_base = n_pw_base; pw_en = n_pw_en;
    end
    err_left = n_err;
    hsel = sel; htrans = tr; hwrite = wr; hsize = sz; haddr = {20'hABCDE, a}; hwdata = wd; hready = rdy;
    exp_ready = err_left != 2;
    exp_resp = err_left != 0;
    exp_rdata = prd_v ? prd_data : 32'd0;
    if (pw_v && rdy) begin
      for (int i = 0; i < 4; i++) if (pw_en[i]) ref_mem[pw_base + i] = wd[8*i +: 8];
      pw_v = 0;
    end
    acc = sel && tr[1] && rdy && err_left != 2;
    legal = (sz == 0) || (sz == 1 && a[0] == 1'b0) || (sz == 2 && a[1:0] == 2'd0);
    base = {a[11:2], 2'b00};
    n_prd_v = acc && legal && !wr;
    n_prd_data = {ref_mem[base + 3], ref_mem[base + 2], ref_mem[base + 1], ref_mem[base]};
    n_pw_v = acc && legal && wr;
    n_pw_base = base;
    for (int i = 0; i < 4; i++) n_pw_en[i] = (sz == 2) || (sz == 1 && (i / 2) == int'(a[1])) || (sz == 0 && i == int'(a[1:0]));
    n_err = (acc && !legal) ? 2 : err_left > 0 ? err_left - 1 : 0;
    last_rdy = rdy;
  endtask
  task automatic idle(input logic [31:0] wd = 32'd0);
    cyc(1'b0, 2'd0, 1'b0, 3'd0, 12'd0, wd, 1'b1);
  endtask
  task automatic wr(input logic [2:0] sz, input logic [11:0] a, input logic [31:0] wd);
    cyc(1'b1, 2'd2, 1'b1, sz, a, wd, 1'b1);
  endtask
  task automatic rd(input logic [2:0] sz, input logic [11:0] a, input logic [31:0] wd = 32'd0);
    cyc(1'b1, 2'd2, 1'b0, sz, a, wd, 1'b1);
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0; chk_en = 0;
    hsel = 1'b0; htrans = 2'd0; hwrite = 1'b0; hsize = 3'd0; haddr = '0; hwdata = '0; hready = 1'b1;
    prd_v = 0; n_prd_v = 0; pw_v = 0; n_pw_v = 0; err_left = 0; n_err = 0; last_rdy = 1;
    #1;
    chk("rst_hreadyout", {31'd0, hreadyout}, 32'd1);
    chk("rst_hresp", {31'd0, hresp}, 32'd0);
    chk("rst_hrdata", hrdata, 32'd0);
    chk("rst_cen", {31'd0, sram_cen}, 32'd1);
    chk("rst_wen", {28'd0, sram_wen}, 32'hF);
    chk("rst_din", sram_din, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_ready = 1'b1; exp_resp = 1'b0; exp_rdata = 32'd0; chk_en = 1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
    do_reset();
    wr(3'd2, 12'h010, 32'd0); #1 chk("wr_aphase_cen", {31'd0, sram_cen}, 32'd1);
    idle(32'hDEADBEEF); #1 chk("wr_dphase_cen", {31'd0, sram_cen}, 32'd1);
    idle(); #1;
    chk("drain_cen", {31'd0, sram_cen}, 32'd0);
    chk("drain_wen", {28'd0, sram_wen}, 32'h0);
    chk("drain_addr", {22'd0, sram_addr}, 32'h4);
    chk("drain_din", sram_din, 32'hDEADBEEF);
    idle(); #1 chk("empty_cen", {31'd0, sram_cen}, 32'd1);
    rd(3'd2, 12'h010); #1;
    chk("rd_cen", {31'd0, sram_cen}, 32'd0);
    chk("rd_wen", {28'd0, sram_wen}, 32'hF);
    chk("rd_addr", {22'd0, sram_addr}, 32'h4);
    idle(); #1 chk("rd_010", hrdata, 32'hDEADBEEF);
    wr(3'd2, 12'h020, 32'd0);
    rd(3'd2, 12'h020, 32'h11223344); #1 chk("raw_rd_wen", {28'd0, sram_wen}, 32'hF);
    rd(3'd2, 12'h020); #1;
    chk("raw_merge1", hrdata, 32'h11223344);
    chk("raw_hold_addr", {22'd0, sram_addr}, 32'h8);
    rd(3'd2, 12'h020); #1 chk("raw_merge2", hrdata, 32'h11223344);
    idle(); #1;
    chk("raw_merge3", hrdata, 32'h11223344);
    chk("raw_drain_wen", {28'd0, sram_wen}, 32'h0);
    chk("raw_drain_din", sram_din, 32'h11223344);
    idle();
    wr(3'd0, 12'h023, 32'd0);
    rd(3'd2, 12'h020, 32'hAA000000);
    idle(); #1;
    chk("byte_merge", hrdata, 32'hAA223344);
    chk("byte_drain_wen", {28'd0, sram_wen}, 32'h7);
    wr(3'd1, 12'h032, 32'd0);
    wr(3'd0, 12'h031, 32'hBEEF0000);
    wr(3'd2, 12'h034, 32'h00007700);
    idle(32'hCAFEF00D);
    rd(3'd2, 12'h030);
    rd(3'd2, 12'h034); #1 chk("mix_030", hrdata, 32'hBEEF7700);
    rd(3'd1, 12'h032); #1 chk("mix_034", hrdata, 32'hCAFEF00D);
    rd(3'd0, 12'h035);
    idle(); #1 chk("mix_byte_rd", hrdata, 32'hCAFEF00D);
    idle();
    rd(3'd1, 12'h001); #1 chk("err_aphase_cen", {31'd0, sram_cen}, 32'd1);
    cyc(1'b0, 2'd0, 1'b0, 3'd0, 12'd0, 32'd0, 1'b0); #1;
    chk("err1_ready", {31'd0, hreadyout}, 32'd0);
    chk("err1_resp", {31'd0, hresp}, 32'd1);
    chk("err1_cen", {31'd0, sram_cen}, 32'd1);
    idle(); #1;
    chk("err2_ready", {31'd0, hreadyout}, 32'd1);
    chk("err2_resp", {31'd0, hresp}, 32'd1);
    chk("err2_cen", {31'd0, sram_cen}, 32'd1);
    idle(); #1 chk("err_done_resp", {31'd0, hresp}, 32'd0);
    cyc(1'b1, 2'd2, 1'b0, 3'd2, 12'h002, 32'd0, 1'b1);
    cyc(1'b0, 2'd0, 1'b0, 3'd0, 12'd0, 32'd0, 1'b0);
    cyc(1'b1, 2'd2, 1'b1, 3'd3, 12'h000, 32'd0, 1'b1); #1 chk("err2_illegal_cen", {31'd0, sram_cen}, 32'd1);
    rd(3'd2, 12'h010); #1;
    chk("reerr1_block_cen", {31'd0, sram_cen}, 32'd1);
    chk("reerr1_ready", {31'd0, hreadyout}, 32'd0);
    idle(); idle();
    cyc(1'b1, 2'd2, 1'b0, 3'd2, 12'h010, 32'd0, 1'b0); #1 chk("nohready_cen", {31'd0, sram_cen}, 32'd1);
    idle(); #1 chk("nohready_hrdata", hrdata, 32'd0);
    wr(3'd2, 12'h040, 32'd0);
    idle(32'h0BADF00D);
    idle(); idle();
    rd(3'd2, 12'h040);
    idle(); #1 chk("prior_040", hrdata, 32'h0BADF00D);
    wr(3'd2, 12'h040, 32'd0);
    rd(3'd2, 12'h040, 32'h12345678);
    rd(3'd2, 12'h040); #1 chk("pre_rst_merge", hrdata, 32'h12345678);
    do_reset();
    {ref_mem[12'h043], ref_mem[12'h042], ref_mem[12'h041], ref_mem[12'h040]} = 32'h0BADF00D;
    rd(3'd2, 12'h040);
    idle(); #1 chk("post_rst_040", hrdata, 32'h0BADF00D);
    idle();
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
